// File: rtl/wb_pkg.sv
// Shared Wishbone package: responder FSM state encoding and a constant log2 helper.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_WAIT = 2'd1,
        WB_ACK  = 2'd2
    } wb_state_e;

    // Ceiling log2 for elaboration-time width calculations; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_ram_mem.sv
// Byte-lane RAM: synchronous write, synchronous write-first read on a single index port.
module wb_ram_mem
    import wb_pkg::*;
#(
    parameter int unsigned dat_width = 32,
    parameter int unsigned sel_width = dat_width / 8,
    parameter int unsigned depth     = 1024,
    localparam int unsigned IDX_W    = clog2(depth)
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [sel_width-1:0] sel,
    input  logic [IDX_W-1:0]     idx,
    input  logic [dat_width-1:0] din,
    output logic [dat_width-1:0] dout
);

    logic [dat_width-1:0] mem_q [depth];
    logic [dat_width-1:0] merged_c;

    // Stored word with the enabled byte lanes replaced by write data.
    always_comb begin
        merged_c = mem_q[idx];
        for (int unsigned b = 0; b < sel_width; b++) begin
            if (sel[b]) begin
                merged_c[b*8 +: 8] = din[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[idx] <= merged_c;
        end
        dout <= we ? merged_c : mem_q[idx];
    end

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic RAM responder with programmable wait states and a one-cycle ack.
// Optional out-of-range error terminate when WB_RAM_ERR_EN is defined.
module wb_ram_slave
    import wb_pkg::*;
#(
    parameter int unsigned adr_width   = 32,
    parameter int unsigned dat_width   = 32,
    parameter int unsigned sel_width   = dat_width / 8,
    parameter int unsigned depth       = 1024,
    parameter int unsigned wait_states = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [adr_width-1:0] wb_adr,
    input  logic [dat_width-1:0] wb_datwr,
    output logic [dat_width-1:0] wb_datrd,
    input  logic [sel_width-1:0] wb_sel,
    input  logic                 wb_we,
    input  logic                 wb_stb,
    input  logic                 wb_cyc,
    output logic                 wb_ack
`ifdef WB_RAM_ERR_EN
    ,
    output logic                 wb_err
`endif
);

    localparam int unsigned LSB   = clog2(sel_width);
    localparam int unsigned IDX_W = clog2(depth);
    localparam int unsigned CNT_W = 4;

    wb_state_e            state_q;
    wb_state_e            state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic                 req_c;
    logic                 commit_c;
    logic                 oor_c;
    logic                 mem_we_c;
    logic [IDX_W-1:0]     req_idx_c;
    logic [IDX_W-1:0]     mem_idx_c;
    logic [IDX_W-1:0]     idx_q;
    logic [dat_width-1:0] mem_dout;
    logic                 rd_valid_q;
    logic                 ack_q;
    logic                 adr_unused;

    assign req_c      = wb_cyc & wb_stb;
    assign req_idx_c  = wb_adr[LSB +: IDX_W];
    assign adr_unused = ^wb_adr;

`ifdef WB_RAM_ERR_EN
    logic err_q;

    // Any address bit above the word index means the byte address is past the RAM.
    assign oor_c  = |(wb_adr >> (LSB + IDX_W));
    assign wb_err = err_q;
`else
    assign oor_c  = 1'b0;
`endif

    // Next-state and commit decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit_c = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (req_c) begin
                    if (wait_states == 0) begin
                        state_d  = WB_ACK;
                        commit_c = 1'b1;
                    end else begin
                        state_d = WB_WAIT;
                        cnt_d   = CNT_W'(wait_states - 1);
                    end
                end
            end
            WB_WAIT: begin
                if (!req_c) begin
                    state_d = WB_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d  = WB_ACK;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WB_ACK: begin
                state_d = WB_IDLE;
            end
            default: begin
                state_d = WB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= WB_IDLE;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            idx_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= commit_c & ~oor_c;
            if (commit_c) begin
                idx_q      <= req_idx_c;
                rd_valid_q <= ~oor_c;
            end
        end
    end

`ifdef WB_RAM_ERR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= commit_c & oor_c;
        end
    end
`endif

    // Hold the RAM index between commits so the read word stays stable after ack.
    assign mem_idx_c = commit_c ? req_idx_c : idx_q;
    assign mem_we_c  = commit_c & wb_we & ~oor_c & ~reset;

    wb_ram_mem #(
        .dat_width (dat_width),
        .sel_width (sel_width),
        .depth     (depth)
    ) u_mem (
        .clock (clock),
        .we    (mem_we_c),
        .sel   (wb_sel),
        .idx   (mem_idx_c),
        .din   (wb_datwr),
        .dout  (mem_dout)
    );

    assign wb_ack   = ack_q;
    assign wb_datrd = rd_valid_q ? mem_dout : '0;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Randomized self-checking bench for wb_ram_slave: one instance with 0 and one with 3 wait states.
module tb_wb_ram_slave;

    logic        clk;
    logic        rst [2];
    logic [31:0] adr [2];
    logic [31:0] dwr [2];
    logic [31:0] drd [2];
    logic [3:0]  sel [2];
    logic        we  [2];
    logic        stb [2];
    logic        cyc [2];
    logic        ack [2];
`ifdef WB_RAM_ERR_EN
    logic        err [2];
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [2][1024];

    wb_ram_slave #(.wait_states(0)) u_dut0 (
        .clock    (clk),
        .reset    (rst[0]),
        .wb_adr   (adr[0]),
        .wb_datwr (dwr[0]),
        .wb_datrd (drd[0]),
        .wb_sel   (sel[0]),
        .wb_we    (we[0]),
        .wb_stb   (stb[0]),
        .wb_cyc   (cyc[0]),
        .wb_ack   (ack[0])
`ifdef WB_RAM_ERR_EN
        ,
        .wb_err   (err[0])
`endif
    );

    wb_ram_slave #(.wait_states(3)) u_dut3 (
        .clock    (clk),
        .reset    (rst[1]),
        .wb_adr   (adr[1]),
        .wb_datwr (dwr[1]),
        .wb_datrd (drd[1]),
        .wb_sel   (sel[1]),
        .wb_we    (we[1]),
        .wb_stb   (stb[1]),
        .wb_cyc   (cyc[1]),
        .wb_ack   (ack[1])
`ifdef WB_RAM_ERR_EN
        ,
        .wb_err   (err[1])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % 1024);
    endfunction

    function automatic logic out_of_range(input logic [31:0] a);
`ifdef WB_RAM_ERR_EN
        return a >= 32'd4096;
`else
        return (a != a);
`endif
    endfunction

    function automatic logic err_of(input int d);
`ifdef WB_RAM_ERR_EN
        return err[d];
`else
        return (d != d);
`endif
    endfunction

    // One complete transfer, checked against the array model.
    task automatic xfer(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] dat, input logic [3:0] s, output logic [31:0] rd);
        int          lat;
        logic        got_ack;
        logic        got_err;
        logic        oor;
        logic [31:0] exp_rd;
        lat     = 0;
        got_ack = 1'b0;
        got_err = 1'b0;
        rd      = '0;
        oor     = out_of_range(a);
        exp_rd  = oor ? 32'h0 : model[d][word_of(a)];
        @(negedge clk);
        adr[d] = a; dwr[d] = dat; sel[d] = s; we[d] = w;
        cyc[d] = 1'b1; stb[d] = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (ack[d] || err_of(d)) begin
                lat     = i;
                got_ack = ack[d];
                got_err = err_of(d);
                rd      = drd[d];
                break;
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
        check_eq("latency", 32'(lat), 32'(wait_of(d) + 1));
        check_eq("ack", 32'(got_ack), 32'(!oor));
`ifdef WB_RAM_ERR_EN
        check_eq("err", 32'(got_err), 32'(oor));
`endif
        if (!w || oor) begin
            check_eq("rdata", rd, exp_rd);
        end
        if (w && !oor) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[d][word_of(a)][b*8 +: 8] = dat[b*8 +: 8];
            end
        end
        @(negedge clk);
        check_eq("ack_pulse", 32'(ack[d] | err_of(d)), 32'h0);
        if (!w) begin
            check_eq("rd_hold", drd[d], exp_rd);
        end
    endtask

    // Request held high continuously: one ack every wait_states+2 cycles.
    task automatic back_to_back(input int d, input int cycles);
        int ws;
        ws = wait_of(d);
        @(negedge clk);
        adr[d] = 32'h10; we[d] = 1'b0; sel[d] = 4'hF;
        cyc[d] = 1'b1; stb[d] = 1'b1;
        for (int n = 1; n <= cycles; n++) begin
            @(negedge clk);
            check_eq("b2b_ack", 32'(ack[d]), 32'((n % (ws + 2)) == ws + 1));
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rdv;
        logic [31:0] a;
        logic [31:0] r_old;
        int          acks;
        int          d;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; adr[i] = '0; dwr[i] = '0; sel[i] = '0;
            we[i] = 1'b0; stb[i] = 1'b0; cyc[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq("reset_ack", 32'(ack[i]), 32'h0);
            check_eq("reset_datrd", drd[i], 32'h0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;

        for (int i = 0; i < 16; i++) begin
            xfer(0, 1'b1, 32'(i * 4), $urandom, 4'hF, rdv);
            xfer(1, 1'b1, 32'(i * 4), $urandom, 4'hF, rdv);
        end

        // Basic write/read and byte lanes, no wait states.
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rdv);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rdv);
        check_eq("plan_rd", rdv, 32'hDEADBEEF);
        xfer(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, rdv);
        xfer(0, 1'b1, 32'h10, 32'h11223344, 4'h0, rdv);
        xfer(0, 1'b0, 32'h12, 32'h0, 4'h0, rdv);
        check_eq("plan_lane", rdv, 32'hDEADBEAA);

        // Address range: wrap without the error option, err terminate with it.
        xfer(0, 1'b1, 32'h1000, 32'h55, 4'hF, rdv);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, rdv);
`ifndef WB_RAM_ERR_EN
        check_eq("plan_wrap", rdv, 32'h55);
`endif
        xfer(0, 1'b0, 32'h1000, 32'h0, 4'h0, rdv);

        back_to_back(0, 12);
        back_to_back(1, 20);

        // Abort during WAIT: no ack, memory untouched.
        @(negedge clk);
        adr[1] = 32'h20; dwr[1] = 32'h12345678; sel[1] = 4'hF; we[1] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        @(negedge clk);
        stb[1] = 1'b0; cyc[1] = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack[1]) acks++;
        end
        check_eq("abort_noack", 32'(acks), 32'h0);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, rdv);

        // Reset in WAIT drops the pending write and clears read data.
        r_old = model[1][9];
        xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, rdv);
        @(negedge clk);
        adr[1] = 32'h24; dwr[1] = 32'hCAFEF00D; sel[1] = 4'hF; we[1] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
        check_eq("rst_ack", 32'(ack[1]), 32'h0);
        check_eq("rst_datrd", drd[1], 32'h0);
        repeat (4) @(negedge clk);
        check_eq("rst_quiet", 32'(ack[1]), 32'h0);
        xfer(1, 1'b0, 32'h24, 32'h0, 4'h0, rdv);
        check_eq("rst_nowrite", rdv, r_old);

        // Randomized mix on both instances.
        for (int k = 0; k < 80; k++) begin
            d = k % 2;
            a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
            xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), rdv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
